// File: rtl/stateful_alu_rmw.sv
// Stateful ALU with per-instance state RAM, page-table isolation and atomic
// read-modify-write ops (fetch-add, max-store). One op in flight at a time:
// IDLE -> READ -> EXEC -> OUT -> IDLE, result held until downstream accepts.
module stateful_alu_rmw #(
    parameter int unsigned ACTION_LEN = 64,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned STAGE_ID   = 0,
    parameter int unsigned ACTION_ID  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ACTION_LEN-1:0]   action_in,
    input  logic                    action_valid,
    input  logic [DATA_WIDTH-1:0]   operand_1_in,
    input  logic [DATA_WIDTH-1:0]   operand_2_in,
    input  logic [DATA_WIDTH-1:0]   operand_3_in,
    output logic                    ready_out,
    input  logic [2*ADDR_WIDTH-1:0] page_tbl_out,
    input  logic                    page_tbl_out_valid,
    output logic [DATA_WIDTH-1:0]   container_out,
    output logic                    container_out_valid,
    input  logic                    ready_in,
    output logic                    overflow_out
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned OPC_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    localparam logic [OPC_W-1:0] OP_ADD   = 8'h01;
    localparam logic [OPC_W-1:0] OP_SUB   = 8'h02;
    localparam logic [OPC_W-1:0] OP_LOADD = 8'h07;
    localparam logic [OPC_W-1:0] OP_STORE = 8'h08;
    localparam logic [OPC_W-1:0] OP_ADDI  = 8'h09;
    localparam logic [OPC_W-1:0] OP_SUBI  = 8'h0A;
    localparam logic [OPC_W-1:0] OP_LOAD  = 8'h0B;
    localparam logic [OPC_W-1:0] OP_FADD  = 8'h0C;
    localparam logic [OPC_W-1:0] OP_MAXST = 8'h0D;
    localparam logic [OPC_W-1:0] OP_SET   = 8'h0E;

    // Control / output registers
    logic [1:0]            state_q,  state_d;
    logic                  ready_q,  ready_d;
    logic                  valid_q,  valid_d;
    logic                  flag_q,   flag_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    // Captured operation
    logic [OPC_W-1:0]      opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] op1_q,    op1_d;
    logic [DATA_WIDTH-1:0] op2_q,    op2_d;
    logic [DATA_WIDTH-1:0] op3_q,    op3_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  ovf_q,    ovf_d;

    // Pending RAM write, committed only at the output handshake
    logic                  we_q,     we_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;

    // State RAM and its read register (not reset)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] m_q;

    // Accept-time decode
    logic [OPC_W-1:0]      opcode_c;
    logic [ADDR_WIDTH-1:0] off_c;
    logic [ADDR_WIDTH-1:0] base_c;
    logic [ADDR_WIDTH-1:0] len_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic                  is_ram_c;
    logic                  ovf_c;

    // Execute-stage datapath
    logic [DATA_WIDTH-1:0] exec_result_c;
    logic                  exec_we_c;
    logic [DATA_WIDTH-1:0] exec_wdata_c;
    logic [DATA_WIDTH-1:0] m_inc_c;
    logic [DATA_WIDTH-1:0] max_c;

    logic                  mem_we_c;
    logic                  unused_c;

    assign unused_c = ^{action_in[ACTION_LEN-OPC_W-1:0], 32'(STAGE_ID), 32'(ACTION_ID)};

    // Decode opcode, page-relative address and out-of-page condition
    always_comb begin
        opcode_c = action_in[ACTION_LEN-1 -: OPC_W];
        off_c    = operand_2_in[ADDR_WIDTH-1:0];
        base_c   = page_tbl_out[ADDR_WIDTH-1:0];
        len_c    = page_tbl_out[2*ADDR_WIDTH-1:ADDR_WIDTH];
        addr_c   = base_c + off_c;
        is_ram_c = (opcode_c == OP_LOAD)  || (opcode_c == OP_STORE) ||
                   (opcode_c == OP_LOADD) || (opcode_c == OP_FADD)  ||
                   (opcode_c == OP_MAXST);
        ovf_c    = is_ram_c && ((off_c > len_c) || !page_tbl_out_valid);
    end

    // Result and write-back value for the captured op
    always_comb begin
        m_inc_c       = m_q + DATA_WIDTH'(1);
        max_c         = (m_q > op1_q) ? m_q : op1_q;
        exec_result_c = op3_q;
        exec_we_c     = 1'b0;
        exec_wdata_c  = op1_q;
        if (!ovf_q) begin
            case (opcode_q)
                OP_ADD, OP_ADDI: exec_result_c = op1_q + op2_q;
                OP_SUB, OP_SUBI: exec_result_c = op1_q - op2_q;
                OP_SET:          exec_result_c = op2_q;
                OP_LOAD:         exec_result_c = m_q;
                OP_STORE: begin
                    exec_result_c = op3_q;
                    exec_we_c     = 1'b1;
                    exec_wdata_c  = op1_q;
                end
                OP_LOADD: begin
                    exec_result_c = m_inc_c;
                    exec_we_c     = 1'b1;
                    exec_wdata_c  = m_inc_c;
                end
                OP_FADD: begin
                    exec_result_c = m_q;
                    exec_we_c     = 1'b1;
                    exec_wdata_c  = m_q + op1_q;
                end
                OP_MAXST: begin
                    exec_result_c = max_c;
                    exec_we_c     = 1'b1;
                    exec_wdata_c  = max_c;
                end
                default:         exec_result_c = op3_q;
            endcase
        end
    end

    // Next-state and register-update logic for the op sequencer
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        flag_d   = flag_q;
        result_d = result_q;
        opcode_d = opcode_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        op3_d    = op3_q;
        addr_d   = addr_q;
        ovf_d    = ovf_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (action_valid && ready_q) begin
                    opcode_d = opcode_c;
                    op1_d    = operand_1_in;
                    op2_d    = operand_2_in;
                    op3_d    = operand_3_in;
                    addr_d   = addr_c;
                    ovf_d    = ovf_c;
                    ready_d  = 1'b0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = exec_result_c;
                we_d     = exec_we_c;
                wdata_d  = exec_wdata_c;
                flag_d   = ovf_q;
                valid_d  = 1'b1;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Sequencer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            flag_q   <= 1'b0;
            result_q <= '0;
            opcode_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            op3_q    <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            flag_q   <= flag_d;
            result_q <= result_d;
            opcode_q <= opcode_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op3_q    <= op3_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    // Write only on the output handshake; reset in the same cycle suppresses it
    assign mem_we_c = rst_n && (state_q == ST_OUT) && ready_in && we_q;

    // State RAM: synchronous read in READ, deferred write at handshake
    always_ff @(posedge clk) begin
        if (state_q == ST_READ) begin
            m_q <= mem_q[addr_q];
        end
        if (mem_we_c) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign ready_out           = ready_q;
    assign container_out       = result_q;
    assign container_out_valid = valid_q;
    assign overflow_out        = flag_q;

endmodule

// File: tb/tb_stateful_alu_rmw.sv
// Directed self-checking bench for stateful_alu_rmw.
module tb_stateful_alu_rmw;

    logic        clk;
    logic        rst_n;
    logic [63:0] action_in;
    logic        action_valid;
    logic [31:0] operand_1_in;
    logic [31:0] operand_2_in;
    logic [31:0] operand_3_in;
    logic        ready_out;
    logic [9:0]  page_tbl_out;
    logic        page_tbl_out_valid;
    logic [31:0] container_out;
    logic        container_out_valid;
    logic        ready_in;
    logic        overflow_out;

    int checks   = 0;
    int failures = 0;

    stateful_alu_rmw dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .action_in           (action_in),
        .action_valid        (action_valid),
        .operand_1_in        (operand_1_in),
        .operand_2_in        (operand_2_in),
        .operand_3_in        (operand_3_in),
        .ready_out           (ready_out),
        .page_tbl_out        (page_tbl_out),
        .page_tbl_out_valid  (page_tbl_out_valid),
        .container_out       (container_out),
        .container_out_valid (container_out_valid),
        .ready_in            (ready_in),
        .overflow_out        (overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string sub, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, sub, obs, exp);
        end
    endtask

    // mode 0: normal handshake; mode 1: 10-cycle downstream stall; mode 2: reset while in OUT
    task automatic run_op(input string tag, input logic [7:0] opc,
                          input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] op3,
                          input logic [4:0] base, input logic [4:0] len, input logic pv,
                          input logic [31:0] exp_out, input logic exp_ovf, input int mode);
        int n;
        action_in          = {opc, 56'h0};
        operand_1_in       = op1;
        operand_2_in       = op2;
        operand_3_in       = op3;
        page_tbl_out       = {len, base};
        page_tbl_out_valid = pv;
        ready_in           = (mode == 1) ? 1'b0 : 1'b1;
        chk(tag, "ready_before", 32'(ready_out), 32'd1);
        action_valid = 1'b1;
        @(posedge clk); #1;
        action_valid = 1'b0;
        n = 1;
        while (!container_out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, "latency", 32'(n), 32'd3);
        chk(tag, "out", container_out, exp_out);
        chk(tag, "ovf", 32'(overflow_out), 32'(exp_ovf));
        if (mode == 1) begin
            for (int i = 0; i < 10; i++) begin
                action_valid = i[0];
                action_in    = {8'h01, 56'h0};
                @(posedge clk); #1;
                if (i == 9) begin
                    chk(tag, "hold_valid", 32'(container_out_valid), 32'd1);
                    chk(tag, "hold_out", container_out, exp_out);
                    chk(tag, "hold_ready", 32'(ready_out), 32'd0);
                end
            end
            action_valid = 1'b0;
            ready_in     = 1'b1;
            @(posedge clk); #1;
        end else if (mode == 2) begin
            rst_n    = 1'b0;
            ready_in = 1'b1;
            @(posedge clk); #1;
            chk(tag, "rst_ready", 32'(ready_out), 32'd1);
            chk(tag, "rst_valid", 32'(container_out_valid), 32'd0);
            chk(tag, "rst_out", container_out, 32'd0);
            chk(tag, "rst_ovf", 32'(overflow_out), 32'd0);
            rst_n = 1'b1;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
        chk(tag, "valid_after", 32'(container_out_valid), 32'd0);
    endtask

    initial begin
        rst_n              = 1'b0;
        action_in          = '0;
        action_valid       = 1'b0;
        operand_1_in       = '0;
        operand_2_in       = '0;
        operand_3_in       = '0;
        page_tbl_out       = {5'd8, 5'd4};
        page_tbl_out_valid = 1'b1;
        ready_in           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "ready", 32'(ready_out), 32'd1);
        chk("reset", "valid", 32'(container_out_valid), 32'd0);
        chk("reset", "out", container_out, 32'd0);
        chk("reset", "ovf", 32'(overflow_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Arithmetic / non-RAM ops
        run_op("add",   8'h01, 32'd7, 32'd5, 32'd0, 5'd4, 5'd8, 1'b1, 32'd12, 1'b0, 0);
        run_op("subi",  8'h0A, 32'd3, 32'd5, 32'd0, 5'd4, 5'd8, 1'b1, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("set",   8'h0E, 32'd9, 32'h55, 32'd0, 5'd4, 5'd8, 1'b1, 32'h55, 1'b0, 0);
        run_op("unk",   8'h42, 32'd1, 32'd2, 32'h77, 5'd4, 5'd8, 1'b1, 32'h77, 1'b0, 0);
        run_op("add_npv", 8'h01, 32'd1, 32'd1, 32'd0, 5'd4, 5'd8, 1'b0, 32'd2, 1'b0, 0);

        // Store / load, then wrapped address
        run_op("store3", 8'h08, 32'hDEAD, 32'd3, 32'h1111, 5'd4, 5'd8, 1'b1, 32'h1111, 1'b0, 0);
        run_op("load3",  8'h0B, 32'd0, 32'd3, 32'h0, 5'd4, 5'd8, 1'b1, 32'hDEAD, 1'b0, 0);
        run_op("st_wrap", 8'h08, 32'hBEEF, 32'd3, 32'h0, 5'd30, 5'd8, 1'b1, 32'h0, 1'b0, 0);
        run_op("ld_ram1", 8'h0B, 32'd0, 32'd1, 32'h0, 5'd0, 5'd8, 1'b1, 32'hBEEF, 1'b0, 0);

        // loadd wrap-around
        run_op("st_fe",  8'h08, 32'hFFFF_FFFE, 32'd5, 32'h0, 5'd4, 5'd8, 1'b1, 32'h0, 1'b0, 0);
        run_op("loadd1", 8'h07, 32'd0, 32'd5, 32'h0, 5'd4, 5'd8, 1'b1, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("loadd2", 8'h07, 32'd0, 32'd5, 32'h0, 5'd4, 5'd8, 1'b1, 32'h0, 1'b0, 0);
        run_op("loadd3", 8'h07, 32'd0, 32'd5, 32'h0, 5'd4, 5'd8, 1'b1, 32'h1, 1'b0, 0);
        run_op("ld_ldd", 8'h0B, 32'd0, 32'd5, 32'h0, 5'd4, 5'd8, 1'b1, 32'h1, 1'b0, 0);

        // fetch-add and max-store
        run_op("st5",   8'h08, 32'd5, 32'd6, 32'h0, 5'd4, 5'd8, 1'b1, 32'h0, 1'b0, 0);
        run_op("fadd",  8'h0C, 32'd10, 32'd6, 32'h0, 5'd4, 5'd8, 1'b1, 32'd5, 1'b0, 0);
        run_op("ld15",  8'h0B, 32'd0, 32'd6, 32'h0, 5'd4, 5'd8, 1'b1, 32'd15, 1'b0, 0);
        run_op("max9",  8'h0D, 32'd9, 32'd6, 32'h0, 5'd4, 5'd8, 1'b1, 32'd15, 1'b0, 0);
        run_op("max20", 8'h0D, 32'd20, 32'd6, 32'h0, 5'd4, 5'd8, 1'b1, 32'd20, 1'b0, 0);
        run_op("ld20",  8'h0B, 32'd0, 32'd6, 32'h0, 5'd4, 5'd8, 1'b1, 32'd20, 1'b0, 0);

        // Page boundary: off == len legal, off > len overflows
        run_op("st_eq",  8'h08, 32'hA5A5, 32'd8, 32'h31, 5'd4, 5'd8, 1'b1, 32'h31, 1'b0, 0);
        run_op("ld_eq",  8'h0B, 32'd0, 32'd8, 32'h0, 5'd4, 5'd8, 1'b1, 32'hA5A5, 1'b0, 0);
        run_op("st_13",  8'h08, 32'h1357, 32'd9, 32'h0, 5'd4, 5'd15, 1'b1, 32'h0, 1'b0, 0);
        run_op("st_ovf", 8'h08, 32'h9999, 32'd9, 32'hCC, 5'd4, 5'd8, 1'b1, 32'hCC, 1'b1, 0);
        run_op("ld_ovf", 8'h0B, 32'd0, 32'd9, 32'hAB, 5'd4, 5'd8, 1'b1, 32'hAB, 1'b1, 0);
        run_op("ld_13",  8'h0B, 32'd0, 32'd9, 32'h0, 5'd4, 5'd15, 1'b1, 32'h1357, 1'b0, 0);

        // Invalid page entry
        run_op("st_4",   8'h08, 32'h4444, 32'd0, 32'h0, 5'd4, 5'd8, 1'b1, 32'h0, 1'b0, 0);
        run_op("st_npv", 8'h08, 32'h5555, 32'd0, 32'hDD, 5'd4, 5'd8, 1'b0, 32'hDD, 1'b1, 0);
        run_op("ld_4",   8'h0B, 32'd0, 32'd0, 32'h0, 5'd4, 5'd8, 1'b1, 32'h4444, 1'b0, 0);

        // Downstream stall, then reset during OUT
        run_op("st_stall", 8'h08, 32'h6666, 32'd2, 32'hEE, 5'd4, 5'd8, 1'b1, 32'hEE, 1'b0, 1);
        run_op("ld_stall", 8'h0B, 32'd0, 32'd2, 32'h0, 5'd4, 5'd8, 1'b1, 32'h6666, 1'b0, 0);
        run_op("st_rst",   8'h08, 32'h7777, 32'd2, 32'hFF, 5'd4, 5'd8, 1'b1, 32'hFF, 1'b0, 2);
        run_op("ld_rst",   8'h0B, 32'd0, 32'd2, 32'h0, 5'd4, 5'd8, 1'b1, 32'h6666, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
